// File: rtl/mc_pkg.sv
// Shared types and constants for the Monte Carlo pi run controller.
// The pi result is unsigned Q6.23, so a hit fraction scaled by 4 needs a shift of 25 bits.
package mc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    WARMUP,
    RUN,
    CALC,
    DONE
  } mc_state_t;

  localparam int PI_WIDTH      = 29;
  localparam int PI_FRAC_BITS  = 23;
  localparam int PI_SHIFT_BASE = PI_FRAC_BITS + 2;

endpackage

// File: rtl/mc_sample_counter.sv
// Clearable sample/hit counter pair; last_sample flags the cycle the 2^LOG2_SAMPLES-th valid sample is counted.
// Counts are registered (visible one edge after the sample); there is no backpressure.
module mc_sample_counter #(
  parameter int LOG2_SAMPLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  sample_valid,
  input  logic                  sample_hit,
  output logic [LOG2_SAMPLES:0] hit_cnt,
  output logic                  last_sample
);

  localparam int CW = LOG2_SAMPLES + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'((64'd1 << LOG2_SAMPLES) - 64'd1);

  logic [CW-1:0] sample_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      hit_cnt    <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
      hit_cnt    <= '0;
    end else if (sample_valid) begin
      sample_cnt <= sample_cnt + CW'(1);
      if (sample_hit) hit_cnt <= hit_cnt + CW'(1);
    end
  end

  assign last_sample = sample_valid && !clr && (sample_cnt == LAST_IDX);

endmodule

// File: rtl/mc_run_ctrl.sv
// Run controller: seeds the PRBS, discards a warm-up window, counts 2^LOG2_SAMPLES samples, forms pi = 4*hits/N.
// pi_out and done appear two edges after the final valid sample; start while busy is dropped, abort returns to IDLE.
module mc_run_ctrl
  import mc_pkg::*;
#(
  parameter int LOG2_SAMPLES  = 16,
  parameter int WARMUP_CYCLES = 64,
  parameter int SEED_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SEED_WIDTH-1:0] seed_in,
  output logic [SEED_WIDTH-1:0] prbs_seed,
  output logic                  prbs_load,
  output logic                  prbs_en,
  input  logic                  sample_valid,
  input  logic                  sample_hit,
  output logic                  busy,
  output logic                  done,
  output logic [PI_WIDTH-1:0]   pi_out
);

  localparam int WU_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;

  mc_state_t             state_q, state_nx;
  logic [WU_W-1:0]       wu_cnt;
  logic [LOG2_SAMPLES:0] hit_cnt;
  logic                  last_sample;
  logic                  cnt_clr;
  logic                  accept;

  assign accept  = (state_q == IDLE) && start && !abort;
  assign cnt_clr = (state_q == SEED) || (state_q == WARMUP);

  mc_sample_counter #(
    .LOG2_SAMPLES(LOG2_SAMPLES)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .sample_valid(sample_valid && (state_q == RUN)),
    .sample_hit  (sample_hit),
    .hit_cnt     (hit_cnt),
    .last_sample (last_sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (accept) state_nx = SEED;
      SEED:    state_nx = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
      WARMUP:  if (wu_cnt <= WU_W'(1)) state_nx = RUN;
      RUN:     if (last_sample) state_nx = CALC;
      CALC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_nx = IDLE;
  end

  always_comb begin
    prbs_load = (state_q == SEED);
    prbs_en   = (state_q == WARMUP) || (state_q == RUN);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  // Warm-up down-counter is loaded while SEED is presented to the PRBS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wu_cnt <= '0;
    end else if (state_q == SEED) begin
      wu_cnt <= WU_W'(WARMUP_CYCLES);
    end else if (state_q == WARMUP) begin
      wu_cnt <= wu_cnt - WU_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prbs_seed <= '0;
      pi_out    <= '0;
    end else begin
      if (accept) prbs_seed <= seed_in;
      if ((state_q == CALC) && !abort)
        pi_out <= PI_WIDTH'(hit_cnt) << (PI_SHIFT_BASE - LOG2_SAMPLES);
    end
  end

endmodule

// File: tb/tb_mc_run_ctrl.sv
// Directed bench for mc_run_ctrl: two instances (warm-up 3 and warm-up 0), LOG2_SAMPLES=4.
// Inputs change on the falling edge; outputs are observed on the falling edge before inputs change.
module tb_mc_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, abort;
  logic [31:0] seed_in;
  logic        sample_valid, sample_hit;

  logic [31:0] a_seed, b_seed;
  logic        a_load, b_load, a_en, b_en, a_busy, b_busy, a_done, b_done;
  logic [28:0] a_pi, b_pi;

  int n_tests = 0;
  int n_fail  = 0;

  logic pat_v [64];
  logic pat_h [64];
  int   pat_len;

  int          r_done_cyc, r_ndone, r_nen, r_nload;
  logic [28:0] r_pi, r_pi_before;
  logic [31:0] r_seed;

  always #5 clk = ~clk;

  mc_run_ctrl #(.LOG2_SAMPLES(4), .WARMUP_CYCLES(3), .SEED_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .seed_in(seed_in),
    .prbs_seed(a_seed), .prbs_load(a_load), .prbs_en(a_en),
    .sample_valid(sample_valid), .sample_hit(sample_hit),
    .busy(a_busy), .done(a_done), .pi_out(a_pi)
  );

  mc_run_ctrl #(.LOG2_SAMPLES(4), .WARMUP_CYCLES(0), .SEED_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .seed_in(seed_in),
    .prbs_seed(b_seed), .prbs_load(b_load), .prbs_en(b_en),
    .sample_valid(sample_valid), .sample_hit(sample_hit),
    .busy(b_busy), .done(b_done), .pi_out(b_pi)
  );

  // Cycle 0 carries start, cycle 1 is SEED; RUN begins at cycle 2+warm. SEED/WARMUP cycles carry junk hits.
  task automatic run_dut(input bit sel, input int warm, input logic [31:0] seed);
    logic        ld, en, dn;
    logic [28:0] pi_o, prev_pi;
    logic [31:0] sd;
    int          k;
    r_done_cyc = -1; r_ndone = 0; r_nen = 0; r_nload = 0;
    r_pi = '0; r_pi_before = '0; r_seed = '0;
    @(negedge clk);
    prev_pi = sel ? b_pi : a_pi;
    start_a = !sel; start_b = sel; seed_in = seed;
    sample_valid = 1'b0; sample_hit = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      ld   = sel ? b_load : a_load;
      en   = sel ? b_en   : a_en;
      dn   = sel ? b_done : a_done;
      pi_o = sel ? b_pi   : a_pi;
      sd   = sel ? b_seed : a_seed;
      if (ld) begin r_nload++; r_seed = sd; end
      if (en) r_nen++;
      if (dn) begin
        r_ndone++;
        if (r_done_cyc < 0) begin
          r_done_cyc  = c;
          r_pi        = pi_o;
          r_pi_before = prev_pi;
        end
      end
      prev_pi = pi_o;
      if (c < 2 + warm) begin
        sample_valid = 1'b1; sample_hit = 1'b1;
      end else begin
        k = c - 2 - warm;
        sample_valid = (k < pat_len) ? pat_v[k] : 1'b0;
        sample_hit   = (k < pat_len) ? pat_h[k] : 1'b0;
      end
    end
    sample_valid = 1'b0; sample_hit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 0; start_b = 0; abort = 0; seed_in = '0;
    sample_valid = 0; sample_hit = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({a_busy, a_done, a_load, a_en} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {a_busy, a_done, a_load, a_en});
    end
    n_tests++;
    if (a_pi !== 29'd0) begin n_fail++; $display("FAIL reset_pi: got %0h expected 0", a_pi); end
    n_tests++;
    if (a_seed !== 32'd0) begin n_fail++; $display("FAIL reset_seed: got %0h expected 0", a_seed); end
    n_tests++;
    if ({b_busy, b_en, b_pi} !== 31'd0) begin
      n_fail++; $display("FAIL reset_b: got %0h expected 0", {b_busy, b_en, b_pi});
    end
    rst = 1'b0;
  endtask

  task automatic test_all_hits();
    for (int i = 0; i < 16; i++) begin pat_v[i] = 1'b1; pat_h[i] = 1'b1; end
    pat_len = 16;
    run_dut(1'b0, 3, 32'hACE1);
    n_tests++;
    if (r_nload !== 1) begin n_fail++; $display("FAIL all_hits_load_cnt: got %0d expected 1", r_nload); end
    n_tests++;
    if (r_seed !== 32'hACE1) begin n_fail++; $display("FAIL all_hits_seed: got %0h expected ace1", r_seed); end
    n_tests++;
    if (r_nen !== 19) begin n_fail++; $display("FAIL all_hits_en_cycles: got %0d expected 19", r_nen); end
    n_tests++;
    if (r_done_cyc !== 22) begin n_fail++; $display("FAIL all_hits_done_cyc: got %0d expected 22", r_done_cyc); end
    n_tests++;
    if (r_ndone !== 1) begin n_fail++; $display("FAIL all_hits_done_pulses: got %0d expected 1", r_ndone); end
    n_tests++;
    if (r_pi !== 29'h2000000) begin n_fail++; $display("FAIL all_hits_pi: got %0h expected 2000000", r_pi); end
    n_tests++;
    if (r_pi_before !== 29'd0) begin n_fail++; $display("FAIL all_hits_pi_early: got %0h expected 0", r_pi_before); end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 31; i++) begin
      pat_v[i] = (i % 2 == 0);
      pat_h[i] = (i % 2 == 0) && (i / 2 < 13);
    end
    pat_len = 31;
    run_dut(1'b0, 3, 32'h5555);
    n_tests++;
    if (r_done_cyc !== 37) begin n_fail++; $display("FAIL gaps_done_cyc: got %0d expected 37", r_done_cyc); end
    n_tests++;
    if (r_pi !== 29'd27262976) begin n_fail++; $display("FAIL gaps_pi: got %0d expected 27262976", r_pi); end
    n_tests++;
    if (r_pi_before !== 29'h2000000) begin n_fail++; $display("FAIL gaps_pi_hold: got %0h expected 2000000", r_pi_before); end
    n_tests++;
    if (r_nen !== 34) begin n_fail++; $display("FAIL gaps_en_cycles: got %0d expected 34", r_nen); end
    n_tests++;
    if (r_ndone !== 1) begin n_fail++; $display("FAIL gaps_done_pulses: got %0d expected 1", r_ndone); end
  endtask

  task automatic test_abort();
    int nld, ndn;
    nld = 0; ndn = 0;
    @(negedge clk); start_a = 1'b1; seed_in = 32'h1234;
    @(negedge clk); start_a = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 5; c <= 12; c++) begin
      @(negedge clk);
      if (a_load) nld++;
      sample_valid = 1'b1; sample_hit = 1'b1;
      start_a = (c == 6); if (c == 6) seed_in = 32'hFFFF;
    end
    @(negedge clk);
    if (a_load) nld++;
    sample_valid = 1'b0; sample_hit = 1'b0;
    n_tests++;
    if (a_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", a_busy); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_tests++;
    if ({a_busy, a_en, a_load} !== 3'b000) begin
      n_fail++; $display("FAIL abort_ctl_after: got %b expected 000", {a_busy, a_en, a_load});
    end
    n_tests++;
    if (a_seed !== 32'h1234) begin n_fail++; $display("FAIL abort_start_ignored: got %0h expected 1234", a_seed); end
    n_tests++;
    if (nld !== 0) begin n_fail++; $display("FAIL abort_reload: got %0d expected 0", nld); end
    repeat (5) begin @(negedge clk); if (a_done) ndn++; end
    n_tests++;
    if (ndn !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", ndn); end
    n_tests++;
    if (a_pi !== 29'd27262976) begin n_fail++; $display("FAIL abort_pi_hold: got %0d expected 27262976", a_pi); end
  endtask

  task automatic test_no_warmup();
    for (int i = 0; i < 16; i++) begin pat_v[i] = 1'b1; pat_h[i] = 1'b0; end
    pat_len = 16;
    run_dut(1'b1, 0, 32'h0F0F);
    n_tests++;
    if (r_done_cyc !== 19) begin n_fail++; $display("FAIL nowarm_done_cyc: got %0d expected 19", r_done_cyc); end
    n_tests++;
    if (r_nen !== 16) begin n_fail++; $display("FAIL nowarm_en_cycles: got %0d expected 16", r_nen); end
    n_tests++;
    if (r_pi !== 29'd0) begin n_fail++; $display("FAIL nowarm_pi: got %0h expected 0", r_pi); end
    n_tests++;
    if (r_ndone !== 1) begin n_fail++; $display("FAIL nowarm_done_pulses: got %0d expected 1", r_ndone); end
  endtask

  task automatic test_rst_mid_run();
    @(negedge clk); start_a = 1'b1; seed_in = 32'hBEEF;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_warmup_en: got %b expected 1", a_en); end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({a_busy, a_en, a_load, a_done} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_async_ctl: got %b expected 0000", {a_busy, a_en, a_load, a_done});
    end
    n_tests++;
    if ({a_seed, a_pi} !== 61'd0) begin
      n_fail++; $display("FAIL rst_async_regs: got seed %0h pi %0h expected 0", a_seed, a_pi);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) begin pat_v[i] = 1'b1; pat_h[i] = (i < 12); end
    pat_len = 16;
    run_dut(1'b0, 3, 32'h00C0FFEE);
    n_tests++;
    if (r_pi !== 29'h1800000) begin n_fail++; $display("FAIL rst_rerun_pi: got %0h expected 1800000", r_pi); end
    n_tests++;
    if (r_done_cyc !== 22) begin n_fail++; $display("FAIL rst_rerun_done_cyc: got %0d expected 22", r_done_cyc); end
    n_tests++;
    if (r_seed !== 32'h00C0FFEE) begin n_fail++; $display("FAIL rst_rerun_seed: got %0h expected c0ffee", r_seed); end
  endtask

  task automatic test_stray_hits();
    for (int i = 0; i < 21; i++) begin
      pat_v[i] = (i >= 10) || (i % 2 == 0);
      pat_h[i] = (i < 10) && (i % 2 == 1);
    end
    pat_len = 21;
    run_dut(1'b0, 3, 32'h7777);
    n_tests++;
    if (r_pi !== 29'd0) begin n_fail++; $display("FAIL stray_pi: got %0h expected 0", r_pi); end
    n_tests++;
    if (r_done_cyc !== 27) begin n_fail++; $display("FAIL stray_done_cyc: got %0d expected 27", r_done_cyc); end
  endtask

  initial begin
    test_reset();
    test_all_hits();
    test_gaps();
    test_abort();
    test_no_warmup();
    test_rst_mid_run();
    test_stray_hits();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
